// File: rtl/sparse_pkg.sv
// -----------------------------------------------------------------------------
// sparse_pkg
// Shared token definitions for the sparse accelerator tile.
//   - Token layout: bit 16 set marks a control token, bits [15:0] carry the
//     coordinate / position value (data) or the control code (control).
//   - Control codes: 0x1_00LL stop of level LL, 0x1_0100 DONE,
//     0x1_0200 EMPTY (filler pos word produced inside the joiner).
//   - join_class_t classifies the pair of coord heads seen by the joiner.
// -----------------------------------------------------------------------------
package sparse_pkg;

    localparam int TOKEN_W = 17;

    typedef logic [TOKEN_W-1:0] token_t;

    localparam token_t DONE_TOK  = 17'h10100;
    localparam token_t EMPTY_TOK = 17'h10200;
    localparam token_t STOP_BASE = 17'h10000;

    typedef enum logic [2:0] {
        JC_DATA_DATA,   // both heads are coordinates
        JC_DATA_CTRL,   // side 0 coordinate, side 1 control
        JC_CTRL_DATA,   // side 0 control, side 1 coordinate
        JC_STOP_STOP,   // both heads are stop tokens
        JC_DONE_DONE,   // both heads are DONE
        JC_DONE_STOP,   // malformed: side 0 DONE, side 1 stop
        JC_STOP_DONE,   // malformed: side 0 stop, side 1 DONE
        JC_OTHER        // unrecognised control combination
    } join_class_t;

    function automatic logic is_ctrl(input token_t tok);
        return tok[TOKEN_W-1];
    endfunction

    // Stop tokens occupy 0x1_0000..0x1_00FF: only the level byte may be set.
    function automatic logic is_stop(input token_t tok);
        return tok[TOKEN_W-1] && (tok[15:8] == 8'h00);
    endfunction

    function automatic logic is_done(input token_t tok);
        return tok == DONE_TOK;
    endfunction

    function automatic join_class_t classify(input token_t c0, input token_t c1);
        if (!is_ctrl(c0) && !is_ctrl(c1)) return JC_DATA_DATA;
        if (!is_ctrl(c0))                 return JC_DATA_CTRL;
        if (!is_ctrl(c1))                 return JC_CTRL_DATA;
        if (is_stop(c0) && is_stop(c1))   return JC_STOP_STOP;
        if (is_done(c0) && is_done(c1))   return JC_DONE_DONE;
        if (is_done(c0) && is_stop(c1))   return JC_DONE_STOP;
        if (is_stop(c0) && is_done(c1))   return JC_STOP_DONE;
        return JC_OTHER;
    endfunction

endpackage

// File: rtl/sparse_reg_fifo.sv
// -----------------------------------------------------------------------------
// sparse_reg_fifo
// Small register-based FIFO used on each joiner output.
// Ports:
//   clk          in   rising-edge clock
//   i_flush      in   synchronous active-high clear of pointers and count
//   i_clk_en     in   0 = hold all state
//   i_push       in   write i_push_data (ignored when full)
//   i_push_data  in   WIDTH-bit word
//   i_pop        in   drop head word (ignored when empty)
//   o_pop_data   out  head word
//   o_empty      out  no words stored
//   o_full       out  DEPTH words stored
// Push and pop in the same cycle are both honoured; pointers wrap modulo
// DEPTH, which must be a power of two.
// -----------------------------------------------------------------------------
module sparse_reg_fifo #(
    parameter int WIDTH = 17,
    parameter int DEPTH = 2
) (
    input  logic             clk,
    input  logic             i_flush,
    input  logic             i_clk_en,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_push_data,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_pop_data,
    output logic             o_empty,
    output logic             o_full
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [PTR_W:0]   r_count;

    logic w_do_push;
    logic w_do_pop;

    assign o_empty    = (r_count == '0);
    assign o_full     = (r_count == (PTR_W+1)'(DEPTH));
    assign o_pop_data = r_mem[r_rd_ptr];

    assign w_do_push = i_clk_en & i_push & ~o_full;
    assign w_do_pop  = i_clk_en & i_pop  & ~o_empty;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk) begin
        if (i_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // NOTE: storage is deliberately not reset; the count gates every read,
    // so stale contents are never observed and the array stays plain flops.
    always_ff @(posedge clk) begin
        if (w_do_push) r_mem[r_wr_ptr] <= i_push_data;
    end

endmodule

// File: rtl/sparse_joiner_unit.sv
// -----------------------------------------------------------------------------
// sparse_joiner_unit
// Two-input sparse coordinate joiner: merges two sorted (coord,pos) fiber
// streams into one coord stream plus two aligned pos streams, as a union
// (joiner_op=1) or an intersection (joiner_op=0). Stop/DONE tokens pass
// through aligned on all three outputs.
// Ports:
//   clk, flush (sync active-high clear), clk_en (0 = freeze),
//   tile_en (0 = all valid/ready low), joiner_op (1 union, 0 intersect)
//   coord_in_k / pos_in_k   input pairs, valid in / ready out (k = 0,1)
//   coord_out, pos_out_0/1  outputs, valid out / ready in, drained independently
// A side is consumed only as a whole (coord,pos) pair. Emitted words land in
// three output FIFOs in the same edge, so output valid follows a pop by one
// cycle.
// -----------------------------------------------------------------------------
module sparse_joiner_unit
    import sparse_pkg::*;
#(
    parameter int DATA_WIDTH = 16,
    parameter int FIFO_DEPTH = 2
) (
    input  logic                clk,
    input  logic                flush,
    input  logic                clk_en,
    input  logic                tile_en,
    input  logic                joiner_op,

    input  logic [DATA_WIDTH:0] coord_in_0,
    input  logic                coord_in_0_valid,
    output logic                coord_in_0_ready,
    input  logic [DATA_WIDTH:0] pos_in_0,
    input  logic                pos_in_0_valid,
    output logic                pos_in_0_ready,

    input  logic [DATA_WIDTH:0] coord_in_1,
    input  logic                coord_in_1_valid,
    output logic                coord_in_1_ready,
    input  logic [DATA_WIDTH:0] pos_in_1,
    input  logic                pos_in_1_valid,
    output logic                pos_in_1_ready,

    output logic [DATA_WIDTH:0] coord_out,
    output logic                coord_out_valid,
    input  logic                coord_out_ready,
    output logic [DATA_WIDTH:0] pos_out_0,
    output logic                pos_out_0_valid,
    input  logic                pos_out_0_ready,
    output logic [DATA_WIDTH:0] pos_out_1,
    output logic                pos_out_1_valid,
    input  logic                pos_out_1_ready
);

    token_t      w_c0, w_c1, w_p0, w_p1;
    join_class_t w_class;

    logic   w_pop0, w_pop1, w_emit;
    token_t w_out_c, w_out_p0, w_out_p1;

    logic   w_active;
    logic   w_full_c, w_full_p0, w_full_p1;
    logic   w_empty_c, w_empty_p0, w_empty_p1;

    // Holds input readies low on the cycle right after a flush.
    logic   r_post_flush;

    assign w_c0 = coord_in_0;
    assign w_c1 = coord_in_1;
    assign w_p0 = pos_in_0;
    assign w_p1 = pos_in_1;

    assign w_class = classify(w_c0, w_c1);

    always_ff @(posedge clk) begin
        if (flush)       r_post_flush <= 1'b1;
        else if (clk_en) r_post_flush <= 1'b0;
    end

    // A decision is taken only with both pairs present and room in all FIFOs.
    assign w_active = tile_en & clk_en & ~flush & ~r_post_flush
                    & coord_in_0_valid & pos_in_0_valid
                    & coord_in_1_valid & pos_in_1_valid
                    & ~w_full_c & ~w_full_p0 & ~w_full_p1;

    // NOTE: every output of this block is assigned a default before the case,
    // so no path leaves a value held and no latch is inferred.
    always_comb begin
        w_pop0   = 1'b0;
        w_pop1   = 1'b0;
        w_emit   = 1'b0;
        w_out_c  = w_c0;
        w_out_p0 = w_p0;
        w_out_p1 = w_p1;
        case (w_class)
            JC_DATA_DATA: begin
                if (w_c0 == w_c1) begin
                    w_pop0 = 1'b1;
                    w_pop1 = 1'b1;
                    w_emit = 1'b1;
                end else if (w_c0 < w_c1) begin
                    w_pop0   = 1'b1;
                    w_emit   = joiner_op;
                    w_out_p1 = EMPTY_TOK;
                end else begin
                    w_pop1   = 1'b1;
                    w_emit   = joiner_op;
                    w_out_c  = w_c1;
                    w_out_p0 = EMPTY_TOK;
                end
            end
            // Data against a control token: the data side is drained until
            // the other side's fiber boundary is reached.
            JC_DATA_CTRL: begin
                w_pop0   = 1'b1;
                w_emit   = joiner_op;
                w_out_p1 = EMPTY_TOK;
            end
            JC_CTRL_DATA: begin
                w_pop1   = 1'b1;
                w_emit   = joiner_op;
                w_out_c  = w_c1;
                w_out_p0 = EMPTY_TOK;
            end
            JC_STOP_STOP: begin
                w_pop0   = 1'b1;
                w_pop1   = 1'b1;
                w_emit   = 1'b1;
                w_out_p0 = w_c0;
                w_out_p1 = w_c0;
            end
            JC_DONE_DONE: begin
                w_pop0   = 1'b1;
                w_pop1   = 1'b1;
                w_emit   = 1'b1;
                w_out_c  = DONE_TOK;
                w_out_p0 = DONE_TOK;
                w_out_p1 = DONE_TOK;
            end
            JC_DONE_STOP: w_pop1 = 1'b1;
            JC_STOP_DONE: w_pop0 = 1'b1;
            // Unknown control pairs are discarded so the stream cannot lock up.
            default: begin
                w_pop0 = 1'b1;
                w_pop1 = 1'b1;
            end
        endcase
    end

    assign coord_in_0_ready = w_active & w_pop0;
    assign pos_in_0_ready   = w_active & w_pop0;
    assign coord_in_1_ready = w_active & w_pop1;
    assign pos_in_1_ready   = w_active & w_pop1;

    assign coord_out_valid = ~w_empty_c  & tile_en & ~flush;
    assign pos_out_0_valid = ~w_empty_p0 & tile_en & ~flush;
    assign pos_out_1_valid = ~w_empty_p1 & tile_en & ~flush;

    sparse_reg_fifo #(.WIDTH(DATA_WIDTH+1), .DEPTH(FIFO_DEPTH)) u_fifo_coord (
        .clk         (clk),
        .i_flush     (flush),
        .i_clk_en    (clk_en),
        .i_push      (w_active & w_emit),
        .i_push_data (w_out_c),
        .i_pop       (coord_out_valid & coord_out_ready),
        .o_pop_data  (coord_out),
        .o_empty     (w_empty_c),
        .o_full      (w_full_c)
    );

    sparse_reg_fifo #(.WIDTH(DATA_WIDTH+1), .DEPTH(FIFO_DEPTH)) u_fifo_pos0 (
        .clk         (clk),
        .i_flush     (flush),
        .i_clk_en    (clk_en),
        .i_push      (w_active & w_emit),
        .i_push_data (w_out_p0),
        .i_pop       (pos_out_0_valid & pos_out_0_ready),
        .o_pop_data  (pos_out_0),
        .o_empty     (w_empty_p0),
        .o_full      (w_full_p0)
    );

    sparse_reg_fifo #(.WIDTH(DATA_WIDTH+1), .DEPTH(FIFO_DEPTH)) u_fifo_pos1 (
        .clk         (clk),
        .i_flush     (flush),
        .i_clk_en    (clk_en),
        .i_push      (w_active & w_emit),
        .i_push_data (w_out_p1),
        .i_pop       (pos_out_1_valid & pos_out_1_ready),
        .o_pop_data  (pos_out_1),
        .o_empty     (w_empty_p1),
        .o_full      (w_full_p1)
    );

endmodule

// File: tb/tb_sparse_joiner_unit.sv
// -----------------------------------------------------------------------------
// tb_sparse_joiner_unit
// Self-checking bench for sparse_joiner_unit. Expected outputs come from a
// set-based model: per fiber, each coordinate's membership on either side
// decides what the union / intersection emits.
// -----------------------------------------------------------------------------
module tb_sparse_joiner_unit;

    localparam logic [16:0] T_S0    = 17'h10000;
    localparam logic [16:0] T_S1    = 17'h10001;
    localparam logic [16:0] T_DONE  = 17'h10100;
    localparam logic [16:0] T_EMPTY = 17'h10200;
    localparam int          N_COORD = 24;

    logic        clk = 1'b0;
    logic        flush, clk_en, tile_en, joiner_op;
    logic [16:0] coord_in_0, pos_in_0, coord_in_1, pos_in_1;
    logic        coord_in_0_valid, pos_in_0_valid, coord_in_1_valid, pos_in_1_valid;
    logic        coord_in_0_ready, pos_in_0_ready, coord_in_1_ready, pos_in_1_ready;
    logic [16:0] coord_out, pos_out_0, pos_out_1;
    logic        coord_out_valid, pos_out_0_valid, pos_out_1_valid;
    logic        coord_out_ready, pos_out_0_ready, pos_out_1_ready;

    int n_checks = 0;
    int n_fail   = 0;

    logic [16:0] q_c0[$], q_p0[$], q_c1[$], q_p1[$];
    logic [16:0] exp_c[$], exp_p0[$], exp_p1[$];
    logic [16:0] got_c[$], got_p0[$], got_p1[$];

    always #5 clk = ~clk;

    sparse_joiner_unit #(.DATA_WIDTH(16), .FIFO_DEPTH(2)) dut (
        .clk              (clk),
        .flush            (flush),
        .clk_en           (clk_en),
        .tile_en          (tile_en),
        .joiner_op        (joiner_op),
        .coord_in_0       (coord_in_0),
        .coord_in_0_valid (coord_in_0_valid),
        .coord_in_0_ready (coord_in_0_ready),
        .pos_in_0         (pos_in_0),
        .pos_in_0_valid   (pos_in_0_valid),
        .pos_in_0_ready   (pos_in_0_ready),
        .coord_in_1       (coord_in_1),
        .coord_in_1_valid (coord_in_1_valid),
        .coord_in_1_ready (coord_in_1_ready),
        .pos_in_1         (pos_in_1),
        .pos_in_1_valid   (pos_in_1_valid),
        .pos_in_1_ready   (pos_in_1_ready),
        .coord_out        (coord_out),
        .coord_out_valid  (coord_out_valid),
        .coord_out_ready  (coord_out_ready),
        .pos_out_0        (pos_out_0),
        .pos_out_0_valid  (pos_out_0_valid),
        .pos_out_0_ready  (pos_out_0_ready),
        .pos_out_1        (pos_out_1),
        .pos_out_1_valid  (pos_out_1_valid),
        .pos_out_1_ready  (pos_out_1_ready)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    function automatic logic [16:0] dtok(input int v);
        return {1'b0, v[15:0]};
    endfunction

    task automatic idle_inputs();
        coord_in_0_valid = 1'b0; pos_in_0_valid = 1'b0;
        coord_in_1_valid = 1'b0; pos_in_1_valid = 1'b0;
        coord_in_0 = '0; pos_in_0 = '0; coord_in_1 = '0; pos_in_1 = '0;
    endtask

    task automatic pulse_flush();
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic clear_queues();
        q_c0.delete(); q_p0.delete(); q_c1.delete(); q_p1.delete();
        exp_c.delete(); exp_p0.delete(); exp_p1.delete();
    endtask

    // Reference model: builds random fibers as membership sets and derives
    // the joined stream directly from set union / intersection.
    task automatic gen_random(input logic op, input int n_fib);
        logic [16:0] pa [N_COORD];
        logic [16:0] pb [N_COORD];
        bit          ina[N_COORD];
        bit          inb[N_COORD];
        logic [16:0] stop0, stop1;
        clear_queues();
        for (int f = 0; f < n_fib; f++) begin
            for (int c = 0; c < N_COORD; c++) begin
                ina[c] = ($urandom_range(99) < 40);
                inb[c] = ($urandom_range(99) < 40);
                pa[c]  = {1'b0, 16'($urandom)};
                pb[c]  = {1'b0, 16'($urandom)};
                if (ina[c]) begin q_c0.push_back(dtok(c)); q_p0.push_back(pa[c]); end
                if (inb[c]) begin q_c1.push_back(dtok(c)); q_p1.push_back(pb[c]); end
                if (op ? (ina[c] | inb[c]) : (ina[c] & inb[c])) begin
                    exp_c.push_back(dtok(c));
                    exp_p0.push_back(ina[c] ? pa[c] : T_EMPTY);
                    exp_p1.push_back(inb[c] ? pb[c] : T_EMPTY);
                end
            end
            stop0 = T_S0 | 17'($urandom_range(3));
            stop1 = T_S0 | 17'($urandom_range(3));
            q_c0.push_back(stop0); q_p0.push_back(stop0);
            q_c1.push_back(stop1); q_p1.push_back(stop1);
            exp_c.push_back(stop0); exp_p0.push_back(stop0); exp_p1.push_back(stop0);
        end
        q_c0.push_back(T_DONE); q_p0.push_back(T_DONE);
        q_c1.push_back(T_DONE); q_p1.push_back(T_DONE);
        exp_c.push_back(T_DONE); exp_p0.push_back(T_DONE); exp_p1.push_back(T_DONE);
    endtask

    task automatic compare_q(input string tag, input logic [16:0] got[$], input logic [16:0] exp[$]);
        check($sformatf("%s len", tag), got.size(), exp.size());
        for (int i = 0; i < exp.size() && i < got.size(); i++)
            check($sformatf("%s[%0d]", tag, i), got[i], exp[i]);
    endtask

    // Streams the input queues with random valid gaps and output back-pressure
    // (stall percent), collects all output words, then compares.
    task automatic run_stream(input string name, input logic op, input int stall);
        bit cv0 = 0, pv0 = 0, cv1 = 0, pv1 = 0;
        bit pop0, pop1;
        int cyc = 0;
        int tail = 0;
        joiner_op = op;
        got_c.delete(); got_p0.delete(); got_p1.delete();
        while (tail < 6 && cyc < 4000) begin
            if (q_c0.size() > 0) begin
                if (!cv0 && $urandom_range(99) >= stall) cv0 = 1;
                if (!pv0 && $urandom_range(99) >= stall) pv0 = 1;
            end
            if (q_c1.size() > 0) begin
                if (!cv1 && $urandom_range(99) >= stall) cv1 = 1;
                if (!pv1 && $urandom_range(99) >= stall) pv1 = 1;
            end
            coord_in_0_valid = cv0; pos_in_0_valid = pv0;
            coord_in_1_valid = cv1; pos_in_1_valid = pv1;
            coord_in_0 = cv0 ? q_c0[0] : 17'h0beef;
            pos_in_0   = pv0 ? q_p0[0] : 17'h0beef;
            coord_in_1 = cv1 ? q_c1[0] : 17'h0beef;
            pos_in_1   = pv1 ? q_p1[0] : 17'h0beef;
            coord_out_ready = ($urandom_range(99) >= stall);
            pos_out_0_ready = ($urandom_range(99) >= stall);
            pos_out_1_ready = ($urandom_range(99) >= stall);
            @(negedge clk);
            if (coord_in_0_ready | pos_in_0_ready)
                check({name, " pair0"}, pos_in_0_ready, coord_in_0_ready);
            if (coord_in_1_ready | pos_in_1_ready)
                check({name, " pair1"}, pos_in_1_ready, coord_in_1_ready);
            pop0 = cv0 & pv0 & coord_in_0_ready & pos_in_0_ready;
            pop1 = cv1 & pv1 & coord_in_1_ready & pos_in_1_ready;
            if (coord_out_valid & coord_out_ready) got_c.push_back(coord_out);
            if (pos_out_0_valid & pos_out_0_ready) got_p0.push_back(pos_out_0);
            if (pos_out_1_valid & pos_out_1_ready) got_p1.push_back(pos_out_1);
            @(posedge clk); #1;
            if (pop0) begin void'(q_c0.pop_front()); void'(q_p0.pop_front()); cv0 = 0; pv0 = 0; end
            if (pop1) begin void'(q_c1.pop_front()); void'(q_p1.pop_front()); cv1 = 0; pv1 = 0; end
            cyc++;
            if (q_c0.size() == 0 && q_c1.size() == 0 && got_c.size() >= exp_c.size() &&
                got_p0.size() >= exp_p0.size() && got_p1.size() >= exp_p1.size())
                tail++;
        end
        check({name, " finished"}, (cyc < 4000), 1);
        idle_inputs();
        compare_q({name, " coord"}, got_c, exp_c);
        compare_q({name, " pos0"}, got_p0, exp_p0);
        compare_q({name, " pos1"}, got_p1, exp_p1);
    endtask

    task automatic load_spec_streams();
        clear_queues();
        q_c0 = '{dtok(1), dtok(3), dtok(5), T_S0, T_DONE};
        q_p0 = '{dtok(10), dtok(11), dtok(12), T_S0, T_DONE};
        q_c1 = '{dtok(3), dtok(4), dtok(5), T_S0, T_DONE};
        q_p1 = '{dtok(20), dtok(21), dtok(22), T_S0, T_DONE};
    endtask

    task automatic set_intersect_exp();
        exp_c  = '{dtok(3), dtok(5), T_S0, T_DONE};
        exp_p0 = '{dtok(11), dtok(12), T_S0, T_DONE};
        exp_p1 = '{dtok(20), dtok(22), T_S0, T_DONE};
    endtask

    task automatic set_union_exp();
        exp_c  = '{dtok(1), dtok(3), dtok(4), dtok(5), T_S0, T_DONE};
        exp_p0 = '{dtok(10), dtok(11), T_EMPTY, dtok(12), T_S0, T_DONE};
        exp_p1 = '{T_EMPTY, dtok(20), dtok(21), dtok(22), T_S0, T_DONE};
    endtask

    initial begin
        flush = 1'b1; clk_en = 1'b1; tile_en = 1'b1; joiner_op = 1'b0;
        coord_out_ready = 1'b1; pos_out_0_ready = 1'b1; pos_out_1_ready = 1'b1;
        coord_in_0 = dtok(1); pos_in_0 = dtok(2); coord_in_1 = dtok(1); pos_in_1 = dtok(3);
        coord_in_0_valid = 1'b1; pos_in_0_valid = 1'b1;
        coord_in_1_valid = 1'b1; pos_in_1_valid = 1'b1;

        // Reset state: during flush and the cycle after, nothing moves.
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst ready", {coord_in_0_ready, pos_in_0_ready, coord_in_1_ready, pos_in_1_ready}, 0);
        check("rst valid", {coord_out_valid, pos_out_0_valid, pos_out_1_valid}, 0);
        @(posedge clk); #1;
        flush = 1'b0;
        @(negedge clk);
        check("post-flush ready", {coord_in_0_ready, pos_in_0_ready, coord_in_1_ready, pos_in_1_ready}, 0);
        check("post-flush valid", {coord_out_valid, pos_out_0_valid, pos_out_1_valid}, 0);
        @(posedge clk); #1;
        idle_inputs();
        pulse_flush();

        load_spec_streams(); set_intersect_exp(); run_stream("isect", 1'b0, 0);
        load_spec_streams(); set_union_exp();     run_stream("union", 1'b1, 0);
        load_spec_streams(); set_intersect_exp(); run_stream("isect stall", 1'b0, 50);
        load_spec_streams(); set_union_exp();     run_stream("union stall", 1'b1, 50);

        // Empty fiber on side 0.
        clear_queues();
        q_c0 = '{T_S0, T_DONE};          q_p0 = '{T_S0, T_DONE};
        q_c1 = '{dtok(7), T_S0, T_DONE}; q_p1 = '{dtok(30), T_S0, T_DONE};
        exp_c  = '{dtok(7), T_S0, T_DONE};
        exp_p0 = '{T_EMPTY, T_S0, T_DONE};
        exp_p1 = '{dtok(30), T_S0, T_DONE};
        run_stream("empty fiber", 1'b1, 0);

        // Malformed DONE against stop: the stop side is dropped silently.
        clear_queues();
        q_c0 = '{T_DONE};       q_p0 = '{T_DONE};
        q_c1 = '{T_S1, T_DONE}; q_p1 = '{T_S1, T_DONE};
        exp_c = '{T_DONE}; exp_p0 = '{T_DONE}; exp_p1 = '{T_DONE};
        run_stream("done vs stop", 1'b1, 0);

        for (int r = 0; r < 8; r++) begin
            logic op;
            op = 1'($urandom_range(1));
            gen_random(op, $urandom_range(1, 3));
            run_stream($sformatf("rand%0d op%0d", r, op), op, $urandom_range(0, 60));
        end

        // Fill the output FIFOs under back-pressure, then disable the tile.
        joiner_op = 1'b1;
        coord_out_ready = 1'b0; pos_out_0_ready = 1'b0; pos_out_1_ready = 1'b0;
        coord_in_0 = dtok(1); pos_in_0 = dtok(5); coord_in_1 = dtok(2); pos_in_1 = dtok(6);
        coord_in_0_valid = 1'b1; pos_in_0_valid = 1'b1;
        coord_in_1_valid = 1'b1; pos_in_1_valid = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        tile_en = 1'b0;
        coord_out_ready = 1'b1; pos_out_0_ready = 1'b1; pos_out_1_ready = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            check($sformatf("tile_off %0d", i),
                  {coord_in_0_ready, pos_in_0_ready, coord_in_1_ready, pos_in_1_ready,
                   coord_out_valid, pos_out_0_valid, pos_out_1_valid}, 0);
        end
        @(posedge clk); #1;
        coord_out_ready = 1'b0; pos_out_0_ready = 1'b0; pos_out_1_ready = 1'b0;
        tile_en = 1'b1;
        @(negedge clk);
        check("refill valid", {coord_out_valid, pos_out_0_valid, pos_out_1_valid}, 3'b111);
        check("refill head", coord_out, dtok(1));
        check("refill pos1", pos_out_1, T_EMPTY);
        @(posedge clk); #1;
        flush = 1'b1;
        @(negedge clk);
        check("flush valid", {coord_out_valid, pos_out_0_valid, pos_out_1_valid}, 0);
        @(posedge clk); #1;
        flush = 1'b0;
        coord_out_ready = 1'b1; pos_out_0_ready = 1'b1; pos_out_1_ready = 1'b1;
        @(negedge clk);
        check("flushed valid", {coord_out_valid, pos_out_0_valid, pos_out_1_valid}, 0);
        check("flushed ready", {coord_in_0_ready, pos_in_0_ready, coord_in_1_ready, pos_in_1_ready}, 0);
        @(posedge clk); #1;
        idle_inputs();
        @(posedge clk); #1;

        // A fresh stream after the mid-stream flush.
        load_spec_streams(); set_intersect_exp(); run_stream("after flush", 1'b0, 20);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
